// File: rtl/alu_wb_sequencer.sv
// alu_wb_sequencer: Wishbone register front-end that loads 64-bit A/B operands and an
// ALU operation, holds them stable for ALU_LAT cycles after GO, then captures the ALU
// result and flags completion.
// Optional feature: define ALU_SEQ_IRQ_EN to add the level-high irq_o done interrupt.
module alu_wb_sequencer #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned ALU_LAT   = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [63:0] alu_a_o,
  output logic [63:0] alu_b_o,
  output logic [3:0]  alu_op_o,
  input  logic [63:0] alu_result_i,
  output logic        busy_o
`ifdef ALU_SEQ_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  typedef enum logic [1:0] {StIdle, StSettle, StCapture} state_e;

  localparam logic [2:0] IdxALo  = 3'd0;
  localparam logic [2:0] IdxAHi  = 3'd1;
  localparam logic [2:0] IdxBLo  = 3'd2;
  localparam logic [2:0] IdxBHi  = 3'd3;
  localparam logic [2:0] IdxOp   = 3'd4;
  localparam logic [2:0] IdxCtrl = 3'd5;
  localparam logic [2:0] IdxResL = 3'd6;
  localparam logic [2:0] IdxResH = 3'd7;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [31:0] a_lo_q, a_hi_q, b_lo_q, b_hi_q;
  logic [3:0]  op_q;
  logic [63:0] res_q;
  logic        done_q, err_q;
  logic        ack_q;
  logic [31:0] dat_q;
  logic        capture;

  logic        hit, wr, rd;
  logic [2:0]  idx;
  logic        wr_operand, go, clr_done, clr_err, go_start, err_set;
  logic [31:0] rdata;

  // Byte addressing bits are implied by the 32-bit register granularity.
  logic unused_adr;
  assign unused_adr = ^wbs_adr_i[1:0];

  // Merge write data into a register honouring byte-lane selects.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i*8 +: 8] = sel[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
    end
    return r;
  endfunction

  // Bus decode and command strobes; everything commits on the edge ack rises.
  always_comb begin
    hit        = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:5] == BASE_ADDR[31:5]) & ~ack_q;
    wr         = hit & wbs_we_i;
    rd         = hit & ~wbs_we_i;
    idx        = wbs_adr_i[4:2];
    wr_operand = wr & (idx <= IdxOp);
    go         = wr & (idx == IdxCtrl) & wbs_dat_i[0];
    clr_done   = wr & (idx == IdxCtrl) & wbs_dat_i[1];
    clr_err    = wr & (idx == IdxCtrl) & wbs_dat_i[2];
    go_start   = go & ~busy_o;
    err_set    = busy_o & (wr_operand | go);
  end

  // Read-back mux.
  always_comb begin
    rdata = '0;
    unique case (idx)
      IdxALo:  rdata = a_lo_q;
      IdxAHi:  rdata = a_hi_q;
      IdxBLo:  rdata = b_lo_q;
      IdxBHi:  rdata = b_hi_q;
      IdxOp:   rdata = {28'd0, op_q};
      IdxCtrl: rdata = {29'd0, err_q, done_q, busy_o};
      IdxResL: rdata = res_q[31:0];
      IdxResH: rdata = res_q[63:32];
      default: rdata = '0;
    endcase
  end

  // Registered single-cycle ack; read data is zero outside the ack cycle.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= hit;
      dat_q <= rd ? rdata : 32'd0;
    end
  end

  // Operand and op registers; frozen while a sequence is in flight.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      a_lo_q <= '0;
      a_hi_q <= '0;
      b_lo_q <= '0;
      b_hi_q <= '0;
      op_q   <= '0;
    end else if (wr_operand && !busy_o) begin
      case (idx)
        IdxALo:  a_lo_q <= merge_lanes(a_lo_q, wbs_dat_i, wbs_sel_i);
        IdxAHi:  a_hi_q <= merge_lanes(a_hi_q, wbs_dat_i, wbs_sel_i);
        IdxBLo:  b_lo_q <= merge_lanes(b_lo_q, wbs_dat_i, wbs_sel_i);
        IdxBHi:  b_hi_q <= merge_lanes(b_hi_q, wbs_dat_i, wbs_sel_i);
        IdxOp:   if (wbs_sel_i[0]) op_q <= wbs_dat_i[3:0];
        default: ;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (go_start) state_d = StSettle;
      StSettle:  if (cnt_q == 4'd0) state_d = StCapture;
      StCapture: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // FSM outputs: busy covers SETTLE and CAPTURE, i.e. ALU_LAT+1 cycles.
  always_comb begin
    busy_o  = (state_q != StIdle);
    capture = (state_q == StCapture);
  end

  // Settle counter, loaded on GO and run down in SETTLE.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      cnt_q <= '0;
    end else if (go_start) begin
      cnt_q <= 4'(ALU_LAT - 1);
    end else if (state_q == StSettle && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Result capture at the end of the settle window.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      res_q <= '0;
    end else if (capture) begin
      res_q <= alu_result_i;
    end
  end

  // Status flags: GO clears done, CLR_DONE only acts when idle, an error beats CLR_ERR.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (go_start) begin
        done_q <= 1'b0;
      end else if (capture) begin
        done_q <= 1'b1;
      end else if (clr_done && !busy_o) begin
        done_q <= 1'b0;
      end
      if (err_set) begin
        err_q <= 1'b1;
      end else if (clr_err) begin
        err_q <= 1'b0;
      end
    end
  end

`ifdef ALU_SEQ_IRQ_EN
  logic irq_q;

  // Level interrupt raised with done, held until CLR_DONE.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      irq_q <= 1'b0;
    end else if (capture) begin
      irq_q <= 1'b1;
    end else if (clr_done && !busy_o) begin
      irq_q <= 1'b0;
    end
  end

  assign irq_o = irq_q;
`endif

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign alu_a_o   = {a_hi_q, a_lo_q};
  assign alu_b_o   = {b_hi_q, b_lo_q};
  assign alu_op_o  = op_q;

endmodule

// File: tb/tb_alu_wb_sequencer.sv
// Directed bench for alu_wb_sequencer with a two-stage a+b ALU model.
module tb_alu_wb_sequencer;

  localparam logic [31:0] Base = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] dat_w = '0, adr = '0;
  logic        ack;
  logic [31:0] dat_r;
  logic [63:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [63:0] alu_res, pipe1, pipe2;
  logic        busy;
`ifdef ALU_SEQ_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  // ALU model: result = a + b, valid two cycles after operands settle.
  always @(posedge clk) begin
    pipe1 <= alu_a + alu_b;
    pipe2 <= pipe1;
  end
  assign alu_res = pipe2;

  alu_wb_sequencer #(.BASE_ADDR(Base), .ALU_LAT(2)) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .wbs_stb_i   (stb),
    .wbs_cyc_i   (cyc),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_dat_i   (dat_w),
    .wbs_adr_i   (adr),
    .wbs_ack_o   (ack),
    .wbs_dat_o   (dat_r),
    .alu_a_o     (alu_a),
    .alu_b_o     (alu_b),
    .alu_op_o    (alu_op),
    .alu_result_i(alu_res),
    .busy_o      (busy)
`ifdef ALU_SEQ_IRQ_EN
    ,
    .irq_o       (irq)
`endif
  );

  // Raw bus cycle; returns #1 after the edge where ack is seen (or after the budget).
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd, output logic acked);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    acked = 1'b0;
    rd = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        acked = 1'b1;
        rd = dat_r;
        break;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    logic acked;
    wb_xfer(1'b1, a, d, s, rd, acked);
    checks++;
    if (acked !== 1'b1) $display("FAIL write_ack adr=%h got ack=%b want 1", a, acked);
    else passed++;
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] rd);
    logic acked;
    wb_xfer(1'b0, a, 32'd0, 4'hF, rd, acked);
    checks++;
    if (acked !== 1'b1) $display("FAIL read_ack adr=%h got ack=%b want 1", a, acked);
    else passed++;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ack, dat_r, alu_a, alu_b, alu_op, busy} !== '0) begin
      $display("FAIL reset_outputs got ack=%b dat=%h a=%h b=%h op=%h busy=%b want all 0",
               ack, dat_r, alu_a, alu_b, alu_op, busy);
    end else passed++;
`ifdef ALU_SEQ_IRQ_EN
    checks++;
    if (irq !== 1'b0) $display("FAIL reset_irq got %b want 0", irq);
    else passed++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    wb_read(Base + 32'h14, rd);
    checks++;
    if (rd !== 32'h0) $display("FAIL reset_stat got %h want 00000000", rd);
    else passed++;
    wb_read(Base + 32'h18, rd);
    checks++;
    if (rd !== 32'h0) $display("FAIL reset_res_lo got %h want 00000000", rd);
    else passed++;
  endtask

  task automatic test_basic_op();
    logic [31:0] rd;
    int bcnt;
    wb_write(Base + 32'h00, 32'hFFFF_FFFF, 4'hF);
    wb_write(Base + 32'h04, 32'h0000_0001, 4'hF);
    wb_write(Base + 32'h08, 32'h0000_0001, 4'hF);
    wb_write(Base + 32'h0C, 32'h0000_0000, 4'hF);
    wb_write(Base + 32'h10, 32'h0000_0000, 4'hF);
    checks++;
    if (alu_a !== 64'h0000_0001_FFFF_FFFF || alu_b !== 64'h1) begin
      $display("FAIL basic_operands got a=%h b=%h want 00000001ffffffff 1", alu_a, alu_b);
    end else passed++;
    wb_write(Base + 32'h14, 32'h1, 4'hF);
    bcnt = 0;
    for (int i = 0; i < 20 && busy; i++) begin
      bcnt++;
      @(posedge clk); #1;
    end
    checks++;
    if (bcnt != 3) $display("FAIL basic_busy_cycles got %0d want 3", bcnt);
    else passed++;
    wb_read(Base + 32'h14, rd);
    checks++;
    if (rd !== 32'h2) $display("FAIL basic_stat got %h want 00000002", rd);
    else passed++;
    wb_read(Base + 32'h18, rd);
    checks++;
    if (rd !== 32'h0) $display("FAIL basic_res_lo got %h want 00000000", rd);
    else passed++;
    wb_read(Base + 32'h1C, rd);
    checks++;
    if (rd !== 32'h2) $display("FAIL basic_res_hi got %h want 00000002", rd);
    else passed++;
`ifdef ALU_SEQ_IRQ_EN
    checks++;
    if (irq !== 1'b1) $display("FAIL basic_irq got %b want 1", irq);
    else passed++;
`endif
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd;
    wb_write(Base + 32'h00, 32'h0, 4'hF);
    wb_write(Base + 32'h00, 32'hAABB_CCDD, 4'b0101);
    wb_read(Base + 32'h00, rd);
    checks++;
    if (rd !== 32'h00BB_00DD) $display("FAIL byte_lanes got %h want 00bb00dd", rd);
    else passed++;
    wb_write(Base + 32'h10, 32'hFFFF_FFFF, 4'hF);
    wb_read(Base + 32'h10, rd);
    checks++;
    if (rd !== 32'hF || alu_op !== 4'hF) begin
      $display("FAIL op_width got rd=%h op=%h want 0000000f f", rd, alu_op);
    end else passed++;
    wb_write(Base + 32'h10, 32'h0, 4'hF);
  endtask

  task automatic test_write_while_busy();
    logic [31:0] rd;
    // GO together with CLR_DONE: GO wins and the sequence runs.
    wb_write(Base + 32'h14, 32'h3, 4'hF);
    checks++;
    if (busy !== 1'b1) $display("FAIL go_wins_busy got %b want 1", busy);
    else passed++;
    wb_write(Base + 32'h08, 32'h55, 4'hF);
    wait_idle();
    checks++;
    if (alu_b !== 64'h1) $display("FAIL busy_b_unchanged got %h want 1", alu_b);
    else passed++;
    wb_read(Base + 32'h14, rd);
    checks++;
    if (rd !== 32'h6) $display("FAIL busy_err_stat got %h want 00000006", rd);
    else passed++;
    wb_write(Base + 32'h14, 32'h4, 4'hF);
    wb_read(Base + 32'h14, rd);
    checks++;
    if (rd !== 32'h2) $display("FAIL clr_err_stat got %h want 00000002", rd);
    else passed++;
    // New GO overwrote the result: 0x1_00BB00DD + 1.
    wb_read(Base + 32'h18, rd);
    checks++;
    if (rd !== 32'h00BB_00DE) $display("FAIL rerun_res_lo got %h want 00bb00de", rd);
    else passed++;
    wb_read(Base + 32'h1C, rd);
    checks++;
    if (rd !== 32'h1) $display("FAIL rerun_res_hi got %h want 00000001", rd);
    else passed++;
    wb_write(Base + 32'h14, 32'h2, 4'hF);
    wb_read(Base + 32'h14, rd);
    checks++;
    if (rd !== 32'h0) $display("FAIL clr_done_stat got %h want 00000000", rd);
    else passed++;
`ifdef ALU_SEQ_IRQ_EN
    checks++;
    if (irq !== 1'b0) $display("FAIL clr_done_irq got %b want 0", irq);
    else passed++;
`endif
  endtask

  task automatic test_addr_decode();
    logic [31:0] rd;
    logic acked;
    wb_xfer(1'b1, Base + 32'h20, 32'h1234_5678, 4'hF, rd, acked);
    checks++;
    if (acked !== 1'b0) $display("FAIL miss_write_ack got %b want 0", acked);
    else passed++;
    checks++;
    if (alu_a !== 64'h0000_0001_00BB_00DD) begin
      $display("FAIL miss_no_effect got a=%h want 0000000100bb00dd", alu_a);
    end else passed++;
    wb_xfer(1'b0, Base + 32'h20, 32'h0, 4'hF, rd, acked);
    checks++;
    if (acked !== 1'b0) $display("FAIL miss_read_ack got %b want 0", acked);
    else passed++;
    wb_write(32'h3000_0018, 32'hDEAD_BEEF, 4'hF);
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b0) $display("FAIL ack_one_cycle got %b want 0", ack);
    else passed++;
    wb_read(32'h3000_0018, rd);
    checks++;
    if (rd !== 32'h00BB_00DE) $display("FAIL res_ro got %h want 00bb00de", rd);
    else passed++;
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] rd;
    wb_write(Base + 32'h14, 32'h1, 4'hF);
    checks++;
    if (busy !== 1'b1) $display("FAIL midop_started got %b want 1", busy);
    else passed++;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) $display("FAIL midop_busy got %b want 0", busy);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || alu_a !== 64'h0) begin
      $display("FAIL midop_after got busy=%b a=%h want 0 0", busy, alu_a);
    end else passed++;
`ifdef ALU_SEQ_IRQ_EN
    checks++;
    if (irq !== 1'b0) $display("FAIL midop_irq got %b want 0", irq);
    else passed++;
`endif
    wb_read(Base + 32'h14, rd);
    checks++;
    if (rd !== 32'h0) $display("FAIL midop_stat got %h want 00000000", rd);
    else passed++;
    wb_read(Base + 32'h1C, rd);
    checks++;
    if (rd !== 32'h0) $display("FAIL midop_res_hi got %h want 00000000", rd);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic_op();
    test_byte_lanes();
    test_write_while_busy();
    test_addr_decode();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
